// File: rtl/spart_rx.sv
// SPART receive path: 8N1 deserializer with 16x oversampling feeding a small
// show-ahead FIFO, plus sticky overrun / framing error flags.
module spart_rx #(
    parameter int BAUD_DIV   = 54,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_rd,
    input  logic       err_clr,
    output logic [7:0] spart_rx_data,
    output logic       spart_rx_empty,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic tick, fall, push, frame_set;
    logic pop, do_push, overrun_set, full;

    // Synchronizer plus one extra stage of the synchronized value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign tick = (div_q == DIV_W'(BAUD_DIV - 1));
    assign fall = rxd_prev_q & ~rxd_sync_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;

        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                div_d      = '0;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rxd_sync_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxd_sync_q, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        push       = rxd_sync_q;
                        frame_set  = ~rxd_sync_q;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // A pop frees the slot first, so a push into a full FIFO with a pop succeeds.
    always_comb begin
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        pop         = rx_rd && (count_q != '0);
        do_push     = push && (!full || pop);
        overrun_set = push && full && !pop;

        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end

        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end

        frame_err_d = frame_err_q;
        if (frame_set) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign spart_rx_empty = (count_q == '0);
    assign spart_rx_data  = spart_rx_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_overrun     = overrun_q;
    assign rx_frame_err   = frame_err_q;

endmodule
